// File: rtl/ray_pkg.sv
// Shared field layout, miss encoding and scheduler state encoding for the ray closest-hit path.
// The object word is {color[11:0], r[7:0], center[27:0]}.
package ray_pkg;

  localparam int INIT_W    = 28;
  localparam int DIR_W     = 31;
  localparam int OBJ_W     = 48;
  localparam int T_W       = 10;
  localparam int COLOR_W   = 12;
  localparam int COLOR_MSB = 47;
  localparam int COLOR_LSB = 36;
  localparam int R_MSB     = 35;
  localparam int R_LSB     = 28;
  localparam int CENTER_W  = 28;

  localparam logic [T_W-1:0] T_MISS = 10'h3FF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_WAIT,
    ST_DONE
  } state_t;

  function automatic logic [COLOR_W-1:0] obj_color(input logic [OBJ_W-1:0] obj);
    return obj[COLOR_MSB:COLOR_LSB];
  endfunction

endpackage

// File: rtl/ray_closest_hit.sv
// Walks the object list for one ray, holds each sphere on the tracer for TRACE_LAT cycles and keeps the nearest hit.
// n*(TRACE_LAT+2) cycles per ray; the result is held in DONE until hit_ready, and no ray is accepted until then.
module ray_closest_hit
  import ray_pkg::*;
#(
  parameter int          IDX_W     = 4,
  parameter int          TRACE_LAT = 24,
  parameter logic [11:0] BG_COLOR  = 12'h000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ray_valid,
  output logic                 ray_ready,
  input  logic [INIT_W-1:0]    ray_init,
  input  logic [DIR_W-1:0]     ray_dir,
  input  logic [IDX_W:0]       obj_count,
  output logic                 obj_rd_en,
  output logic [IDX_W-1:0]     obj_addr,
  input  logic [OBJ_W-1:0]     obj_data,
  output logic [INIT_W-1:0]    trc_init,
  output logic [DIR_W-1:0]     trc_dir,
  output logic [OBJ_W-1:0]     trc_object,
  input  logic [T_W-1:0]       trc_t,
  output logic                 hit_valid,
  input  logic                 hit_ready,
  output logic                 hit_found,
  output logic [T_W-1:0]       hit_t,
  output logic [COLOR_W-1:0]   hit_color,
  output logic [IDX_W-1:0]     hit_index
);

  localparam int                CNT_W    = $clog2(TRACE_LAT + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(TRACE_LAT - 1);
  localparam logic [IDX_W:0]    MAX_N    = {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W:0]    ONE_N    = {{IDX_W{1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [INIT_W-1:0]    trc_init_q, trc_init_d;
  logic [DIR_W-1:0]     trc_dir_q, trc_dir_d;
  logic [OBJ_W-1:0]     trc_object_q, trc_object_d;
  logic [T_W-1:0]       best_t_q, best_t_d;
  logic [COLOR_W-1:0]   best_color_q, best_color_d;
  logic [IDX_W-1:0]     best_idx_q, best_idx_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W:0]       n_q, n_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                 hit_found_q, hit_found_d;
  logic [T_W-1:0]       hit_t_q, hit_t_d;
  logic [COLOR_W-1:0]   hit_color_q, hit_color_d;
  logic [IDX_W-1:0]     hit_index_q, hit_index_d;

  always_comb begin
    state_d      = state_q;
    trc_init_d   = trc_init_q;
    trc_dir_d    = trc_dir_q;
    trc_object_d = trc_object_q;
    best_t_d     = best_t_q;
    best_color_d = best_color_q;
    best_idx_d   = best_idx_q;
    idx_d        = idx_q;
    n_d          = n_q;
    wait_cnt_d   = wait_cnt_q;
    hit_found_d  = hit_found_q;
    hit_t_d      = hit_t_q;
    hit_color_d  = hit_color_q;
    hit_index_d  = hit_index_q;

    case (state_q)
      ST_IDLE: begin
        if (ray_valid) begin
          trc_init_d   = ray_init;
          trc_dir_d    = ray_dir;
          best_t_d     = T_MISS;
          best_color_d = BG_COLOR;
          best_idx_d   = '0;
          idx_d        = '0;
          n_d          = (obj_count > MAX_N) ? MAX_N : obj_count;
          state_d      = (n_d == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        trc_object_d = obj_data;
        wait_cnt_d   = '0;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt_q == LAST_CNT) begin
          // Strict less-than keeps the earlier index on ties.
          if (trc_t != T_MISS && trc_t < best_t_q) begin
            best_t_d     = trc_t;
            best_color_d = obj_color(trc_object_q);
            best_idx_d   = idx_q;
          end
          idx_d   = idx_q + IDX_W'(1);
          state_d = ({1'b0, idx_q} == n_q - ONE_N) ? ST_DONE : ST_FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (hit_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Result registers only change on entry to DONE so the consumer sees the last answer between rays.
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      hit_found_d = (best_t_d != T_MISS);
      hit_t_d     = best_t_d;
      hit_color_d = best_color_d;
      hit_index_d = best_idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      trc_init_q   <= '0;
      trc_dir_q    <= '0;
      trc_object_q <= '0;
      best_t_q     <= T_MISS;
      best_color_q <= BG_COLOR;
      best_idx_q   <= '0;
      idx_q        <= '0;
      n_q          <= '0;
      wait_cnt_q   <= '0;
      hit_found_q  <= 1'b0;
      hit_t_q      <= T_MISS;
      hit_color_q  <= BG_COLOR;
      hit_index_q  <= '0;
    end else begin
      state_q      <= state_d;
      trc_init_q   <= trc_init_d;
      trc_dir_q    <= trc_dir_d;
      trc_object_q <= trc_object_d;
      best_t_q     <= best_t_d;
      best_color_q <= best_color_d;
      best_idx_q   <= best_idx_d;
      idx_q        <= idx_d;
      n_q          <= n_d;
      wait_cnt_q   <= wait_cnt_d;
      hit_found_q  <= hit_found_d;
      hit_t_q      <= hit_t_d;
      hit_color_q  <= hit_color_d;
      hit_index_q  <= hit_index_d;
    end
  end

  assign ray_ready  = (state_q == ST_IDLE);
  assign hit_valid  = (state_q == ST_DONE);
  assign obj_rd_en  = (state_q == ST_FETCH);
  assign obj_addr   = idx_q;
  assign trc_init   = trc_init_q;
  assign trc_dir    = trc_dir_q;
  assign trc_object = trc_object_q;
  assign hit_found  = hit_found_q;
  assign hit_t      = hit_t_q;
  assign hit_color  = hit_color_q;
  assign hit_index  = hit_index_q;

endmodule
